// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the UART byte-buffering stage.
package uart_fifo_pkg;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GUARD} tx_state_t;
   typedef enum logic       {RX_IDLE, RX_ACK}            rx_state_t;
endpackage

// File: rtl/uart_fifo_sync_fifo.sv
// Single-clock show-ahead FIFO; full/empty come from the registered level.
module sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [LW-1:0]    o_level
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_full, w_empty, w_push, w_pop;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   // A push on a full FIFO is lost even when a pop frees a slot this cycle.
   assign w_push  = i_push && !w_full;
   assign w_pop   = i_pop && !w_empty;

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_level = r_level;
endmodule

// File: rtl/uart_fifo.sv
// TX/RX byte buffers between a host bus and the uart block, with sticky RX overrun.
module uart_fifo
   import uart_fifo_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              tx_wr_i,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic              tx_full_o,
   output logic [LEVEL_W-1:0] tx_level_o,
   input  logic              rx_rd_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_empty_o,
   output logic [LEVEL_W-1:0] rx_level_o,
   output logic              rx_overrun_o,
   input  logic              clr_overrun_i,
   output logic              uart_wr_o,
   output logic [DATA_W-1:0] uart_tx_data_o,
   input  logic              uart_busy_i,
   output logic              uart_rd_o,
   input  logic [DATA_W-1:0] uart_rx_data_i,
   input  logic              uart_valid_i
);
   tx_state_t         r_tx_state, w_tx_next;
   rx_state_t         r_rx_state, w_rx_next;
   logic              r_tx_go;
   logic [DATA_W-1:0] r_tx_data;
   logic              r_overrun;
   logic              w_tx_pop, w_tx_empty;
   logic [DATA_W-1:0] w_tx_dout;
   logic              w_rx_take, w_rx_full;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
      .clk(clk), .reset_i(reset_i),
      .i_push(tx_wr_i), .i_pop(w_tx_pop), .i_din(tx_data_i), .o_dout(w_tx_dout),
      .o_full(tx_full_o), .o_empty(w_tx_empty), .o_level(tx_level_o)
   );

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
      .clk(clk), .reset_i(reset_i),
      .i_push(w_rx_take), .i_pop(rx_rd_i), .i_din(uart_rx_data_i), .o_dout(rx_data_o),
      .o_full(w_rx_full), .o_empty(rx_empty_o), .o_level(rx_level_o)
   );

   // Start condition is sampled a cycle ahead and only while idle, so a busy
   // flag that rises right after GUARD is still seen before the next pop.
   always_comb begin
      w_tx_next = r_tx_state;
      w_tx_pop  = 1'b0;
      case (r_tx_state)
         TX_IDLE: if (r_tx_go) begin
            w_tx_pop  = 1'b1;
            w_tx_next = TX_SEND;
         end
         TX_SEND:  w_tx_next = TX_GUARD;
         TX_GUARD: w_tx_next = TX_IDLE;
         default:  w_tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         r_tx_state <= TX_IDLE;
         r_tx_go    <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_tx_state <= w_tx_next;
         r_tx_go    <= (r_tx_state == TX_IDLE) && !w_tx_pop && !w_tx_empty && !uart_busy_i;
         if (w_tx_pop) r_tx_data <= w_tx_dout;
      end
   end

   assign uart_wr_o      = (r_tx_state == TX_SEND);
   assign uart_tx_data_o = r_tx_data;

   // A byte arriving on a full RX FIFO is still acknowledged, just not stored.
   assign w_rx_take = (r_rx_state == RX_IDLE) && uart_valid_i;

   always_comb begin
      w_rx_next = RX_IDLE;
      if (r_rx_state == RX_IDLE && uart_valid_i) w_rx_next = RX_ACK;
   end

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         r_rx_state <= RX_IDLE;
         r_overrun  <= 1'b0;
      end else begin
         r_rx_state <= w_rx_next;
         if (w_rx_take && w_rx_full) r_overrun <= 1'b1;
         else if (clr_overrun_i)     r_overrun <= 1'b0;
      end
   end

   assign uart_rd_o    = (r_rx_state == RX_ACK);
   assign rx_overrun_o = r_overrun;
endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: directed scenarios plus randomized traffic vs a queue model.
module tb_uart_fifo;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset_i = 1'b0;
   logic          tx_wr_i = 1'b0;
   logic [7:0]    tx_data_i = 8'h00;
   logic          tx_full_o;
   logic [LW-1:0] tx_level_o;
   logic          rx_rd_i = 1'b0;
   logic [7:0]    rx_data_o;
   logic          rx_empty_o;
   logic [LW-1:0] rx_level_o;
   logic          rx_overrun_o;
   logic          clr_overrun_i = 1'b0;
   logic          uart_wr_o;
   logic [7:0]    uart_tx_data_o;
   logic          uart_busy_i;
   logic          uart_rd_o;
   logic [7:0]    uart_rx_data_i = 8'h00;
   logic          uart_valid_i = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_fifo #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset_i(reset_i),
      .tx_wr_i(tx_wr_i), .tx_data_i(tx_data_i), .tx_full_o(tx_full_o), .tx_level_o(tx_level_o),
      .rx_rd_i(rx_rd_i), .rx_data_o(rx_data_o), .rx_empty_o(rx_empty_o), .rx_level_o(rx_level_o),
      .rx_overrun_o(rx_overrun_o), .clr_overrun_i(clr_overrun_i),
      .uart_wr_o(uart_wr_o), .uart_tx_data_o(uart_tx_data_o), .uart_busy_i(uart_busy_i),
      .uart_rd_o(uart_rd_o), .uart_rx_data_i(uart_rx_data_i), .uart_valid_i(uart_valid_i)
   );

   // UART transmitter model: busy rises at the edge that samples wr, stays up busy_len cycles.
   logic       busy_r = 1'b0;
   int         busy_cnt = 0;
   int         busy_len = 10;
   logic       hold_busy = 1'b0;
   logic [7:0] tx_seen[$];
   int         fall_edge = -100;
   int         gap_viol = 0;
   int         wr_while_busy = 0;
   int         rd_cnt = 0;

   assign uart_busy_i = busy_r | hold_busy;

   always @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         busy_r   <= 1'b0;
         busy_cnt <= 0;
      end else if (uart_wr_o) begin
         if (uart_busy_i) wr_while_busy <= wr_while_busy + 1;
         // wr must have risen at least two cycles after busy fell
         if (cyc - fall_edge < 3) gap_viol <= gap_viol + 1;
         tx_seen.push_back(uart_tx_data_o);
         busy_r   <= 1'b1;
         busy_cnt <= busy_len;
      end else if (busy_r) begin
         if (busy_cnt <= 1) begin
            busy_r    <= 1'b0;
            fall_edge <= cyc;
         end
         busy_cnt <= busy_cnt - 1;
      end
   end

   always @(posedge clk) if (reset_i && uart_rd_o) rd_cnt <= rd_cnt + 1;

   task automatic host_write(input logic [7:0] d);
      tx_wr_i = 1'b1; tx_data_i = d;
      @(negedge clk);
      tx_wr_i = 1'b0;
   endtask

   task automatic wait_tx(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (tx_seen.size() >= n && tx_level_o == 0 && !uart_busy_i) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic rx_byte(input logic [7:0] d, output bit ok);
      ok = 1'b0;
      uart_valid_i = 1'b1; uart_rx_data_i = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (uart_rd_o) begin ok = 1'b1; break; end
      end
      @(negedge clk);
      uart_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [12+2*LW:0] got, exp;
      bit ok;
      int s;
      exp = {1'b0, 8'h00, 1'b0, 1'b0, {LW{1'b0}}, 1'b1, {LW{1'b0}}, 1'b0};
      reset_i = 1'b0;
      repeat (3) @(negedge clk);
      got = {uart_wr_o, uart_tx_data_o, uart_rd_o, tx_full_o, tx_level_o, rx_empty_o, rx_level_o, rx_overrun_o};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL reset_vals: got %h expected %h", got, exp); end
      reset_i = 1'b1;
      @(negedge clk);
      rx_byte(8'h99, ok);
      host_write(8'hC3);
      host_write(8'h3C);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (uart_busy_i) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!ok || uart_tx_data_o !== 8'hC3) begin
         failures++; $display("FAIL reset_setup: busy=%b data=%h expected busy=1 data=c3", ok, uart_tx_data_o);
      end
      #2 reset_i = 1'b0;
      #1;
      got = {uart_wr_o, uart_tx_data_o, uart_rd_o, tx_full_o, tx_level_o, rx_empty_o, rx_level_o, rx_overrun_o};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL reset_async: got %h expected %h", got, exp); end
      @(negedge clk);
      reset_i = 1'b1;
      s = tx_seen.size();
      repeat (12) @(negedge clk);
      checks++;
      if (tx_seen.size() != s || tx_level_o !== 0) begin
         failures++; $display("FAIL reset_abandon: sent=%0d level=%0d expected sent=%0d level=0", tx_seen.size(), tx_level_o, s);
      end
   endtask

   task automatic test_tx_timing();
      bit ok;
      busy_len = 10;
      host_write(8'hA5);
      checks++;
      if (uart_wr_o !== 1'b0) begin failures++; $display("FAIL tx_lat_n: got %b expected 0", uart_wr_o); end
      @(negedge clk);
      checks++;
      if (uart_wr_o !== 1'b0) begin failures++; $display("FAIL tx_lat_n1: got %b expected 0", uart_wr_o); end
      @(negedge clk);
      checks++;
      if ({uart_wr_o, uart_tx_data_o} !== {1'b1, 8'hA5}) begin
         failures++; $display("FAIL tx_lat_n2: got wr=%b data=%h expected wr=1 data=a5", uart_wr_o, uart_tx_data_o);
      end
      @(negedge clk);
      checks++;
      if (uart_wr_o !== 1'b0) begin failures++; $display("FAIL tx_lat_pulse: got %b expected 0", uart_wr_o); end
      wait_tx(0, ok);
   endtask

   task automatic test_tx_burst();
      logic [7:0] exp [3];
      int base;
      bit ok;
      exp = '{8'h55, 8'hAA, 8'h0F};
      busy_len = 10;
      base = tx_seen.size();
      hold_busy = 1'b1;
      for (int i = 0; i < 3; i++) host_write(exp[i]);
      checks++;
      if (tx_level_o !== LW'(3)) begin failures++; $display("FAIL burst_level: got %0d expected 3", tx_level_o); end
      hold_busy = 1'b0;
      wait_tx(base + 3, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL burst_drain: sent %0d expected %0d", tx_seen.size() - base, 3); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (tx_seen.size() <= base + i || tx_seen[base+i] !== exp[i]) begin
            failures++; $display("FAIL burst_byte%0d: got %h expected %h", i,
                                 (tx_seen.size() > base + i) ? tx_seen[base+i] : 8'hxx, exp[i]);
         end
      end
      checks++;
      if (tx_level_o !== 0) begin failures++; $display("FAIL burst_level_end: got %0d expected 0", tx_level_o); end
   endtask

   task automatic test_tx_full();
      logic [7:0] q[$];
      logic [7:0] d;
      int base;
      bit ok;
      busy_len = 2;
      base = tx_seen.size();
      hold_busy = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         d = 8'($urandom);
         if (i < DEPTH) q.push_back(d);
         host_write(d);
      end
      checks++;
      if ({tx_full_o, tx_level_o} !== {1'b1, LW'(DEPTH)}) begin
         failures++; $display("FAIL tx_full: got full=%b level=%0d expected full=1 level=%0d", tx_full_o, tx_level_o, DEPTH);
      end
      hold_busy = 1'b0;
      wait_tx(base + DEPTH, ok);
      repeat (20) @(negedge clk);
      checks++;
      if (tx_seen.size() != base + DEPTH) begin
         failures++; $display("FAIL tx_full_count: sent %0d expected %0d", tx_seen.size() - base, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (tx_seen.size() <= base + i || tx_seen[base+i] !== q[i]) begin
            failures++; $display("FAIL tx_full_byte%0d: got %h expected %h", i,
                                 (tx_seen.size() > base + i) ? tx_seen[base+i] : 8'hxx, q[i]);
         end
      end
   endtask

   task automatic test_rx_path();
      int r0;
      r0 = rd_cnt;
      uart_rx_data_i = 8'h41; uart_valid_i = 1'b1;
      @(negedge clk);
      checks++;
      if ({uart_rd_o, rx_empty_o, rx_data_o} !== {1'b1, 1'b0, 8'h41}) begin
         failures++; $display("FAIL rx_capture: got rd=%b empty=%b data=%h expected rd=1 empty=0 data=41",
                              uart_rd_o, rx_empty_o, rx_data_o);
      end
      @(negedge clk);
      uart_valid_i = 1'b0;
      checks++;
      if (uart_rd_o !== 1'b0) begin failures++; $display("FAIL rx_ack_len: got %b expected 0", uart_rd_o); end
      repeat (3) @(negedge clk);
      checks++;
      if (rd_cnt - r0 != 1 || rx_level_o !== LW'(1)) begin
         failures++; $display("FAIL rx_one_ack: got acks=%0d level=%0d expected acks=1 level=1", rd_cnt - r0, rx_level_o);
      end
      rx_rd_i = 1'b1;
      @(negedge clk);
      rx_rd_i = 1'b0;
      checks++;
      if ({rx_empty_o, rx_level_o} !== {1'b1, LW'(0)}) begin
         failures++; $display("FAIL rx_pop: got empty=%b level=%0d expected empty=1 level=0", rx_empty_o, rx_level_o);
      end
   endtask

   task automatic test_rx_overrun();
      logic [7:0] q[$];
      logic [7:0] d;
      int r0, nack;
      bit ok;
      r0 = rd_cnt; nack = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         d = 8'($urandom);
         if (i < DEPTH) q.push_back(d);
         rx_byte(d, ok);
         if (!ok) nack++;
      end
      checks++;
      if (nack != 0 || rd_cnt - r0 != DEPTH + 1) begin
         failures++; $display("FAIL ovr_acks: got acks=%0d timeouts=%0d expected acks=%0d", rd_cnt - r0, nack, DEPTH + 1);
      end
      checks++;
      if ({rx_overrun_o, rx_level_o} !== {1'b1, LW'(DEPTH)}) begin
         failures++; $display("FAIL ovr_set: got ovr=%b level=%0d expected ovr=1 level=%0d", rx_overrun_o, rx_level_o, DEPTH);
      end
      clr_overrun_i = 1'b1;
      @(negedge clk);
      clr_overrun_i = 1'b0;
      checks++;
      if (rx_overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", rx_overrun_o); end
      uart_rx_data_i = 8'hEE; uart_valid_i = 1'b1; clr_overrun_i = 1'b1;
      @(negedge clk);
      clr_overrun_i = 1'b0;
      checks++;
      if ({rx_overrun_o, uart_rd_o} !== 2'b11) begin
         failures++; $display("FAIL ovr_set_wins: got ovr=%b rd=%b expected ovr=1 rd=1", rx_overrun_o, uart_rd_o);
      end
      @(negedge clk);
      uart_valid_i = 1'b0;
      clr_overrun_i = 1'b1;
      @(negedge clk);
      clr_overrun_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (rx_data_o !== q[i]) begin failures++; $display("FAIL ovr_byte%0d: got %h expected %h", i, rx_data_o, q[i]); end
         rx_rd_i = 1'b1;
         @(negedge clk);
         rx_rd_i = 1'b0;
      end
      checks++;
      if ({rx_empty_o, rx_overrun_o} !== 2'b10) begin
         failures++; $display("FAIL ovr_end: got empty=%b ovr=%b expected empty=1 ovr=0", rx_empty_o, rx_overrun_o);
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] b [4];
      bit ok;
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 3; i++) rx_byte(b[i], ok);
      checks++;
      if (rx_level_o !== LW'(3)) begin failures++; $display("FAIL simul_pre: got %0d expected 3", rx_level_o); end
      uart_rx_data_i = b[3]; uart_valid_i = 1'b1; rx_rd_i = 1'b1;
      @(negedge clk);
      rx_rd_i = 1'b0;
      checks++;
      if ({rx_level_o, rx_data_o} !== {LW'(3), b[1]}) begin
         failures++; $display("FAIL simul_level: got level=%0d head=%h expected level=3 head=%h", rx_level_o, rx_data_o, b[1]);
      end
      @(negedge clk);
      uart_valid_i = 1'b0;
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (rx_data_o !== b[i]) begin failures++; $display("FAIL simul_order%0d: got %h expected %h", i, rx_data_o, b[i]); end
         rx_rd_i = 1'b1;
         @(negedge clk);
         rx_rd_i = 1'b0;
      end
   endtask

   task automatic test_random_rx();
      logic [7:0] q[$];
      logic [7:0] d;
      logic ovr, push, pop, clr, ack_pending;
      int pre, pct;
      ovr = 1'b0; ack_pending = 1'b0;
      for (int ph = 0; ph < 2; ph++) begin
         pct = (ph == 0) ? 10 : 70;
         for (int it = 0; it < 150; it++) begin
            push = !ack_pending && ($urandom_range(0, 1) == 1);
            pop  = ($urandom_range(0, 99) < pct);
            clr  = ($urandom_range(0, 9) == 0);
            d    = 8'($urandom);
            uart_valid_i = push; uart_rx_data_i = d; rx_rd_i = pop; clr_overrun_i = clr;
            pre = q.size();
            if (pop && pre > 0) void'(q.pop_front());
            if (push && pre < DEPTH) q.push_back(d);
            if (push && pre == DEPTH) ovr = 1'b1;
            else if (clr)             ovr = 1'b0;
            @(negedge clk);
            checks++;
            if ({rx_level_o, rx_empty_o, rx_overrun_o, uart_rd_o} !== {LW'(q.size()), q.size() == 0, ovr, push}) begin
               failures++;
               $display("FAIL rand_rx_state it=%0d: got level=%0d empty=%b ovr=%b rd=%b expected level=%0d empty=%b ovr=%b rd=%b",
                        it, rx_level_o, rx_empty_o, rx_overrun_o, uart_rd_o, q.size(), q.size() == 0, ovr, push);
            end
            if (q.size() > 0) begin
               checks++;
               if (rx_data_o !== q[0]) begin failures++; $display("FAIL rand_rx_head it=%0d: got %h expected %h", it, rx_data_o, q[0]); end
            end
            ack_pending = push;
         end
      end
      uart_valid_i = 1'b0; rx_rd_i = 1'b0; clr_overrun_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random_tx();
      logic [7:0] q[$];
      logic [7:0] d;
      int base, n;
      bit ok;
      for (int r = 0; r < 4; r++) begin
         q.delete();
         n = $urandom_range(1, DEPTH);
         busy_len = $urandom_range(1, 12);
         base = tx_seen.size();
         for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            q.push_back(d);
            host_write(d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         wait_tx(base + n, ok);
         checks++;
         if (!ok || tx_seen.size() != base + n) begin
            failures++; $display("FAIL rand_tx_count r=%0d: sent %0d expected %0d", r, tx_seen.size() - base, n);
         end
         for (int i = 0; i < n; i++) begin
            if (tx_seen.size() > base + i) begin
               checks++;
               if (tx_seen[base+i] !== q[i]) begin
                  failures++; $display("FAIL rand_tx_byte r=%0d i=%0d: got %h expected %h", r, i, tx_seen[base+i], q[i]);
               end
            end
         end
      end
      checks++;
      if (gap_viol != 0 || wr_while_busy != 0) begin
         failures++; $display("FAIL tx_handshake: got gap_violations=%0d wr_while_busy=%0d expected 0 and 0", gap_viol, wr_while_busy);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_tx_timing();
      test_tx_burst();
      test_tx_full();
      test_rx_path();
      test_rx_overrun();
      test_simultaneous();
      test_random_rx();
      test_random_tx();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
